// File: rtl/pb_pulse_driver.sv
// Event-strobe to fixed-width external pulse driver.
// Queues bursts of events and replays them as slow, evenly spaced pulses.
module pb_pulse_driver #(
  parameter int DIV_COUNT  = 10,
  parameter int HIGH_TICKS = 4,
  parameter int GAP_TICKS  = 4,
  parameter int PEND_W     = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_evt,
  output logic              o_drive,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    GAP
  } state_t;

  localparam int CW =
    (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam int MAXT =
    (HIGH_TICKS > GAP_TICKS) ? HIGH_TICKS : GAP_TICKS;
  localparam int PW =
    (MAXT > 1) ? $clog2(MAXT) : 1;

  localparam logic [CW-1:0] DIV_LAST =
    CW'(DIV_COUNT - 1);
  localparam logic [PW-1:0] HIGH_LAST =
    PW'(HIGH_TICKS - 1);
  localparam logic [PW-1:0] GAP_LAST =
    PW'(GAP_TICKS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [CW-1:0]     div_cnt;
  logic              tick;
  state_t            state;
  state_t            state_nx;
  logic [PW-1:0]     phase;
  logic [PW-1:0]     phase_nx;
  logic              deq;
  logic [PEND_W-1:0] pending;
  logic [PEND_W-1:0] pend_nx;
  logic              ovf_nx;
  logic              has_pend;
  logic              full;

  assign tick     = (div_cnt == DIV_LAST);
  assign has_pend = (pending != '0);
  assign full     = (pending == PEND_MAX);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A tick-less cycle holds everything; a GAP end with work
  // queued skips IDLE so back-to-back pulses stay evenly spaced.
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    deq      = 1'b0;
    if (tick) begin
      unique case (state)
        IDLE: begin
          if (has_pend) begin
            deq      = 1'b1;
            phase_nx = HIGH_LAST;
            state_nx = HIGH;
          end
        end
        HIGH: begin
          if (phase != '0) begin
            phase_nx = phase - 1'b1;
          end else begin
            phase_nx = GAP_LAST;
            state_nx = GAP;
          end
        end
        GAP: begin
          if (phase != '0) begin
            phase_nx = phase - 1'b1;
          end else if (has_pend) begin
            deq      = 1'b1;
            phase_nx = HIGH_LAST;
            state_nx = HIGH;
          end else begin
            state_nx = IDLE;
          end
        end
        default: begin
          state_nx = IDLE;
          phase_nx = '0;
        end
      endcase
    end
  end

  // Event plus dequeue cancel out, so a full queue can still
  // accept an event on the edge a pulse starts.
  always_comb begin
    pend_nx = pending;
    ovf_nx  = 1'b0;
    unique case (1'b1)
      (i_evt & ~deq & ~full): pend_nx = pending + 1'b1;
      (i_evt & ~deq & full):  ovf_nx  = 1'b1;
      (~i_evt & deq):         pend_nx = pending - 1'b1;
      default:                pend_nx = pending;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      phase      <= '0;
      pending    <= '0;
      o_drive    <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_nx;
      phase      <= phase_nx;
      pending    <= pend_nx;
      o_drive    <= (state_nx == HIGH);
      o_overflow <= ovf_nx;
    end
  end

  assign o_busy    = (state != IDLE);
  assign o_pending = pending;

endmodule

// File: doc/pb_pulse_driver.md
# pb_pulse_driver

Output-side counterpart of the push-button input path: accepts single-cycle internal event strobes and turns each one into a clean, slow, fixed-width external pulse. Typical loads are an LED, a test point or an external strobe pin. Events arriving faster than pulses can be emitted are queued in a saturating counter, and events beyond that are dropped and flagged. Timing is derived from a free-running clock-enable prescaler, so pulse widths are human or scope visible.

## Interface
- DIV_COUNT, 10: clocks per prescaler tick; legal range ≥ 2.
- HIGH_TICKS, 4: ticks o_drive stays high per pulse; legal range ≥ 1.
- GAP_TICKS, 4: ticks o_drive stays low after each pulse; legal range ≥ 1.
- PEND_W, 4: width of the pending-event counter, which saturates at 2^PEND_W−1.
- i_clk  in  1  system clock; the block's only clock.
- i_rst  in  1  reset, asynchronous and active-high.
- i_evt  in  1  event strobe; every cycle it is high counts as one event.
- o_drive  out  1  registered external pulse output.
- o_busy  out  1  high whenever the FSM is not IDLE.
- o_pending  out  PEND_W  number of queued events not yet started.
- o_overflow  out  1  one-cycle pulse when an event is dropped.

## Operation
- **Prescaler**
  - Counter runs 0..DIV_COUNT−1 and wraps to 0.
  - tick = (count == DIV_COUNT−1), so tick is high on every DIV_COUNT-th clock.
  - The first tick occurs on the DIV_COUNT-th rising edge after reset release.
- **Pending counter**, updated every clock:
  - evt only: +1.
  - dequeue only: −1.
  - evt and dequeue together: unchanged, no overflow.
  - evt while saturated and no dequeue: count held, o_overflow=1 for that cycle.
- **FSM** has states IDLE, HIGH and GAP. It advances only on tick; all state is held between ticks.
  - IDLE, tick & pending>0: dequeue, load phase=HIGH_TICKS−1, go to HIGH, o_drive←1.
  - IDLE, tick & pending==0: stay in IDLE.
  - HIGH, tick & phase>0: phase−1.
  - HIGH, tick & phase==0: load phase=GAP_TICKS−1, go to GAP, o_drive←0.
  - GAP, tick & phase>0: phase−1.
  - GAP, tick & phase==0 & pending>0: dequeue, go to HIGH directly, reload phase, o_drive←1.
  - GAP, tick & phase==0 & pending==0: go to IDLE.
- o_drive is high exactly while in HIGH.
- o_busy = (state != IDLE).
- Events are accepted in every state.

## Timing
- **Reset values**: prescaler 0, state IDLE, phase 0, pending 0, o_drive 0, o_busy 0, o_overflow 0.
- **Reset mid-pulse**: o_drive drops immediately (asynchronously) and the queue is discarded.
- **Latency**: from i_evt in IDLE with an empty queue, o_drive rises at the next tick edge. That is 1..DIV_COUNT clocks after the event edge.
- **High width**: exactly HIGH_TICKS·DIV_COUNT clocks.
- **Back-to-back low width**: exactly GAP_TICKS·DIV_COUNT clocks between consecutive pulses.
- **Single-pulse busy time**: o_busy lasts (HIGH_TICKS+GAP_TICKS)·DIV_COUNT clocks.
- **o_pending**:
  - It is registered and reflects the counter after each edge.
  - It decrements on the same edge o_drive rises.
- **o_overflow**: registered, one clock wide per dropped event, and asserted on the edge following the dropped i_evt.
- **Arithmetic**: pending never wraps, in either direction.
  - No decrement below 0 (dequeue only happens when pending>0).
  - No increment above 2^PEND_W−1.

## Test plan
Defaults throughout: DIV=10, HIGH=4, GAP=4, PEND_W=4.
- **Reset check**: assert i_rst for 5 clocks, then release. All outputs are 0. No o_drive activity for 200 clocks with i_evt=0.
- **Single event**: one i_evt 3 clocks after reset release.
  - o_drive rises on edge 10 and stays high 40 clocks.
  - o_busy is high for 80 clocks.
  - o_pending shows 1, then 0 at the rise.
  - o_overflow is never asserted.
- **Three events** on consecutive clocks: exactly 3 pulses, each 40 high with 40 low between. o_pending reads 3→2→1→0 at each rising edge of o_drive.
- **Saturation**: i_evt held high for 20 clocks from reset release (edges 1..20).
  - The edge-10 event coincides with a dequeue and is accepted, pending stays at 9.
  - Pending reaches 15, after which 4 o_overflow pulses occur.
  - Exactly 16 pulses are emitted in total.
- **Simultaneous event and dequeue at saturation**: pending=15 in GAP, i_evt on the GAP-end tick. pending stays 15, no o_overflow, and the next pulse starts immediately.
- **Reset mid-pulse**: assert i_rst 15 clocks into a HIGH with pending=5.
  - o_drive goes to 0 asynchronously, and o_pending, o_busy and the prescaler go to 0.
  - After release, no pulses occur without new events.
